// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the fetch/data RAM arbiter.
// Latency: none; types, constants and a pure byte-merge function only.
// Backpressure: not applicable.
package ram_arb_pkg;

  localparam int WD_RAM = 32;
  localparam int WD_BE  = 4;

  typedef enum logic {
    ARB       = 1'b0,
    RMW_MERGE = 1'b1
  } state_e;

  // Bit positions of each requester in the arbiter request/grant vectors
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  // Overlay the enabled bytes of new_w onto old_w
  function automatic logic [WD_RAM-1:0] merge_be(input logic [WD_RAM-1:0] old_w,
                                                 input logic [WD_RAM-1:0] new_w,
                                                 input logic [WD_BE-1:0]  be);
    logic [WD_RAM-1:0] res;
    res = old_w;
    for (int b = 0; b < WD_BE; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the granting edge.
// Backpressure: a requester not granted simply keeps req high and wins the next tie.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_q;

  // On a tie serve the port that was not served last; a lone request wins at once
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_IF] && req[PORT_DM]) begin
      if (last_q == PORT_IF) gnt[PORT_DM] = 1'b1;
      else                   gnt[PORT_IF] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Remember the last granted port; reset to fetch so the data port wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= PORT_IF;
    else if (gnt[PORT_DM]) last_q <= PORT_DM;
    else if (gnt[PORT_IF]) last_q <= PORT_IF;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a fetch port and a data port onto one RAM (registered read, separate write port).
// Latency: gnt combinational; reads/full writes respond 1 cycle after grant, partial writes 2.
// Backpressure: requesters hold until gnt; no grant while a partial-write merge is in flight.
// Build option RAM_ARB_RMW_EN: byte-enable read-modify-write; when undefined be is ignored.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int ram_size_p = 1024,
  localparam int wd_addr_p  = $clog2(ram_size_p)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_if_req,
  input  logic [wd_addr_p-1:0] i_if_addr,
  output logic                 o_if_gnt,
  output logic                 o_if_rvalid,
  output logic [WD_RAM-1:0]    o_if_rdata,
  input  logic                 i_dm_req,
  input  logic                 i_dm_we,
  input  logic [wd_addr_p-1:0] i_dm_addr,
  input  logic [WD_RAM-1:0]    i_dm_wdata,
  input  logic [WD_BE-1:0]     i_dm_be,
  output logic                 o_dm_gnt,
  output logic                 o_dm_rvalid,
  output logic [WD_RAM-1:0]    o_dm_rdata,
  output logic [wd_addr_p-1:0] o_ram_rd_addr,
  input  logic [WD_RAM-1:0]    i_ram_rd_data,
  output logic                 o_ram_wr_en,
  output logic [wd_addr_p-1:0] o_ram_wr_addr,
  output logic [WD_RAM-1:0]    o_ram_wr_data
);

  state_e               state_q, state_d;
  logic [1:0]           req_vec, gnt_vec;
  logic                 arb_en, if_gnt, dm_gnt;
  logic                 dm_partial, dm_full_wr;
  logic                 if_rvalid_q, dm_rvalid_q;
  logic                 wr_en_c;
  logic [wd_addr_p-1:0] rd_addr_c, wr_addr_c;
  logic [WD_RAM-1:0]    wr_data_c;

  // Requests only compete in ARB and never while reset is held
  assign arb_en  = ~rst && (state_q == ARB);
  assign req_vec = {i_dm_req, i_if_req} & {2{arb_en}};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req_vec),
    .gnt (gnt_vec)
  );

  assign if_gnt = gnt_vec[PORT_IF];
  assign dm_gnt = gnt_vec[PORT_DM];

`ifdef RAM_ARB_RMW_EN
  logic [wd_addr_p-1:0] rmw_addr_q;
  logic [WD_RAM-1:0]    rmw_wdata_q, rmw_old_q;
  logic [WD_BE-1:0]     rmw_be_q;
  logic                 rmw_ack_q;

  // be=0000 is an acknowledged no-op; anything between 0000 and 1111 needs a merge
  assign dm_full_wr = i_dm_we && (i_dm_be == {WD_BE{1'b1}});
  assign dm_partial = i_dm_we && (i_dm_be != {WD_BE{1'b1}}) && (i_dm_be != '0);
`else
  logic unused_be;

  assign unused_be  = ^i_dm_be;
  assign dm_full_wr = i_dm_we;
  assign dm_partial = 1'b0;
`endif

  // Next state and the RAM command issued this cycle
  always_comb begin
    state_d   = state_q;
    rd_addr_c = '0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;
    case (state_q)
      ARB: begin
        if (dm_gnt) begin
          rd_addr_c = i_dm_addr;
          if (dm_full_wr) begin
            wr_en_c   = 1'b1;
            wr_addr_c = i_dm_addr;
            wr_data_c = i_dm_wdata;
          end
          if (dm_partial) state_d = RMW_MERGE;
        end else if (if_gnt) begin
          rd_addr_c = i_if_addr;
        end
      end
`ifdef RAM_ARB_RMW_EN
      RMW_MERGE: begin
        // i_ram_rd_data holds the word read at the grant address last cycle
        wr_en_c   = 1'b1;
        wr_addr_c = rmw_addr_q;
        wr_data_c = merge_be(i_ram_rd_data, rmw_wdata_q, rmw_be_q);
        state_d   = ARB;
      end
`endif
      default: state_d = ARB;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end

  // Response valids: one cycle after grant, or one cycle after the merge write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= (dm_gnt && !dm_partial) || (state_q == RMW_MERGE);
    end
  end

`ifdef RAM_ARB_RMW_EN
  // Hold the partial write across the merge and keep the pre-merge word for the ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
      rmw_old_q   <= '0;
      rmw_ack_q   <= 1'b0;
    end else begin
      if (dm_gnt && dm_partial) begin
        rmw_addr_q  <= i_dm_addr;
        rmw_wdata_q <= i_dm_wdata;
        rmw_be_q    <= i_dm_be;
      end
      if (state_q == RMW_MERGE) rmw_old_q <= i_ram_rd_data;
      rmw_ack_q <= (state_q == RMW_MERGE);
    end
  end

  assign o_dm_rdata = !dm_rvalid_q ? '0 : (rmw_ack_q ? rmw_old_q : i_ram_rd_data);
`else
  assign o_dm_rdata = dm_rvalid_q ? i_ram_rd_data : '0;
`endif

  assign o_if_gnt      = if_gnt;
  assign o_dm_gnt      = dm_gnt;
  assign o_if_rvalid   = if_rvalid_q;
  assign o_dm_rvalid   = dm_rvalid_q;
  assign o_if_rdata    = if_rvalid_q ? i_ram_rd_data : '0;
  assign o_ram_rd_addr = rd_addr_c;
  // Reset kills any write in flight, including a merge
  assign o_ram_wr_en   = wr_en_c & ~rst;
  assign o_ram_wr_addr = wr_addr_c;
  assign o_ram_wr_data = wr_data_c;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ram_size_p, default 1024, meaning RAM depth in 32-bit words; wd_addr_p = $clog2(ram_size_p) is derived, not overridable.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_if_req  input  1  fetch port read request.
- i_if_addr  input  wd_addr_p  fetch word address.
- o_if_gnt  output  1  fetch request accepted this cycle.
- o_if_rvalid  output  1  fetch read data valid.
- o_if_rdata  output  32  fetch read data.
- i_dm_req  input  1  data port request.
- i_dm_we  input  1  1 = write, 0 = read.
- i_dm_addr  input  wd_addr_p  data word address.
- i_dm_wdata  input  32  write data.
- i_dm_be  input  4  byte enables; bit n covers bits 8n+7:8n.
- o_dm_gnt  output  1  data request accepted this cycle.
- o_dm_rvalid  output  1  data response valid, for reads and writes.
- o_dm_rdata  output  32  data response word.
- o_ram_rd_addr  output  wd_addr_p  RAM read address.
- i_ram_rd_data  input  32  RAM read data, 1-cycle registered latency.
- o_ram_wr_en  output  1  RAM write enable.
- o_ram_wr_addr  output  wd_addr_p  RAM write address.
- o_ram_wr_data  output  32  RAM write data.

Function
REQ-003 SHALL grant at most one request per cycle; gnt is combinational from req in state ARB; a requester holds req, addr, we, wdata and be stable until gnt.
REQ-004 SHALL arbitrate round-robin: when both requesters are pending, grant the port not granted last; a lone requester is granted immediately.
REQ-005 SHALL drive o_ram_rd_addr with the granted address in the grant cycle, and 0 when no grant is issued.
REQ-006 For a read granted in cycle N, SHALL assert that port's rvalid in cycle N+1 with rdata = i_ram_rd_data.
REQ-007 For a data write with be=4'b1111 granted in cycle N, SHALL assert o_ram_wr_en in cycle N with the write address and data, and assert o_dm_rvalid in cycle N+1 with o_dm_rdata = pre-write word.
REQ-008 SHALL use FSM states ARB, RMW_MERGE:
- ARB -> RMW_MERGE on a granted partial write (be not 1111 and not 0000).
- RMW_MERGE -> ARB unconditionally after 1 cycle.
REQ-009 In RMW_MERGE, SHALL write merge(i_ram_rd_data, latched wdata, latched be), deassert both gnt, and assert o_dm_rvalid the following cycle with o_dm_rdata = pre-merge word.
REQ-010 A write with be=0000 SHALL be acknowledged like REQ-007 with o_ram_wr_en held low.
REQ-011 Consecutive grants to the same address SHALL return post-write data, with no bypass logic, since only one operation issues per cycle.
REQ-012 o_if_rdata and o_dm_rdata SHALL be 0 whenever the corresponding rvalid is low.

Reset
REQ-013 On rst, asynchronously: state = ARB, round-robin pointer = last granted fetch (data port wins the first tie), all rvalid = 0, o_ram_wr_en = 0, both gnt = 0 while rst is high.
REQ-014 Reset during RMW_MERGE SHALL abandon the write (no o_ram_wr_en) and produce no rvalid.

Configuration
REQ-015 Macro RAM_ARB_RMW_EN:
- Defined: partial writes follow REQ-008/009.
- Undefined: the RMW_MERGE state is absent; i_dm_be is ignored and every write is a full-word write per REQ-007.

Structure
REQ-016 Package ram_arb_pkg SHALL hold the state enum, the port-index enum (PORT_IF, PORT_DM), and constants WD_RAM = 32 and WD_BE = 4.
REQ-017 Round-robin selection SHALL be sub-module rr_arb2 (2 requests, 2 one-hot grants, registered last-grant pointer).

Verification
REQ-018 Both req high from reset, reads of addr 5 and 9 -> dm granted cycle 0, if granted cycle 1; o_dm_rvalid cycle 1 and o_if_rvalid cycle 2, with the correct words.
REQ-019 Full write 0xDEADBEEF to addr 3, then dm read of addr 3 the next cycle -> write ack rdata = old word; read returns 0xDEADBEEF.
REQ-020 With RAM_ARB_RMW_EN, addr 7 = 0x11223344, write 0xAABBCCDD with be=0101 -> no gnt during RMW_MERGE; RAM word becomes 0x11BB33DD; ack 2 cycles after grant.
REQ-021 Without RAM_ARB_RMW_EN, same stimulus as REQ-020 -> word becomes 0xAABBCCDD; ack 1 cycle after grant.
REQ-022 rst asserted in RMW_MERGE -> no RAM write, no rvalid; addr 7 unchanged.
REQ-023 if_req held high continuously with dm_req pulsed -> grants alternate; neither port waits more than 1 cycle.
